// File: rtl/buzzer_tone_gen.sv
// rtl/buzzer_tone_gen.sv - glitch-free square-wave tone generator for the board buzzer
//
// Purpose:
//   Converts a note code and octave into a square wave. A new note or octave
//   is adopted only on a half-period boundary, so the speaker never glitches.
//   Every adoption (including falling silent) is flagged by a one-cycle pulse.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   tone_en   in   0 = mute request (treated as note 0)
//   note      in   [3:0] 0 = rest, 1..7 = do..si, 8..15 = rest
//   octave    in   [1:0] 0 = low, 1 = middle, 2/3 = high
//   speaker   out  square-wave drive
//   active    out  1 while playing
//   note_ack  out  one-cycle pulse when a note/octave/rest is adopted
//   cur_note  out  [3:0] note currently sounding (0 when silent)

module buzzer_tone_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tone_en,
  input  logic [3:0] note,
  input  logic [1:0] octave,
  output logic       speaker,
  output logic       active,
  output logic       note_ack,
  output logic [3:0] cur_note
);

  // Low-octave half period in clock cycles for a frequency given in centi-Hz.
  function automatic logic [CNT_W-1:0] half_period(input logic [63:0] f_chz);
    logic [63:0] q;
    q = (64'(CLK_HZ) * 64'd50) / f_chz;
    return q[CNT_W-1:0];
  endfunction

  localparam logic [CNT_W-1:0] H1 = half_period(64'd13081);
  localparam logic [CNT_W-1:0] H2 = half_period(64'd14683);
  localparam logic [CNT_W-1:0] H3 = half_period(64'd16481);
  localparam logic [CNT_W-1:0] H4 = half_period(64'd17461);
  localparam logic [CNT_W-1:0] H5 = half_period(64'd19600);
  localparam logic [CNT_W-1:0] H6 = half_period(64'd22000);
  localparam logic [CNT_W-1:0] H7 = half_period(64'd24694);

  // Requests are compared as {note, octave}; rest is all zeros, which no
  // playable note can produce because playable notes are nonzero.
  localparam logic [5:0] REST = 6'd0;

  typedef enum logic {SILENT, PLAY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] heff_q, heff_d;
  logic [5:0]       req_q, req_d;
  logic             speaker_q, speaker_d;
  logic             ack_q, ack_d;
  logic [3:0]       cur_note_q, cur_note_d;

  logic             req_valid;
  logic [5:0]       req;
  logic [CNT_W-1:0] h_base;
  logic [1:0]       oct_sh;
  logic [CNT_W-1:0] heff_req;
  logic             boundary;

  assign req_valid = tone_en && (note >= 4'd1) && (note <= 4'd7);
  assign req       = req_valid ? {note, octave} : REST;

  always_comb begin
    h_base = H1;
    case (note)
      4'd2:    h_base = H2;
      4'd3:    h_base = H3;
      4'd4:    h_base = H4;
      4'd5:    h_base = H5;
      4'd6:    h_base = H6;
      4'd7:    h_base = H7;
      default: h_base = H1;
    endcase
  end

  // Octaves 2 and 3 both map to the highest octave.
  assign oct_sh   = octave[1] ? 2'd2 : octave;
  assign heff_req = h_base >> oct_sh;
  assign boundary = (cnt_q == heff_q - 1'b1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    heff_d     = heff_q;
    req_d      = req_q;
    speaker_d  = speaker_q;
    ack_d      = 1'b0;
    cur_note_d = cur_note_q;
    case (state_q)
      SILENT: begin
        cnt_d     = '0;
        speaker_d = 1'b0;
        if (req != REST) begin
          state_d    = PLAY;
          req_d      = req;
          heff_d     = heff_req;
          speaker_d  = 1'b1;
          ack_d      = 1'b1;
          cur_note_d = note;
        end
      end
      PLAY: begin
        if (boundary) begin
          cnt_d = '0;
          if (req == req_q) begin
            speaker_d = ~speaker_q;
          end else if (req != REST) begin
            // New half-period length applies to the level that starts now.
            req_d      = req;
            heff_d     = heff_req;
            speaker_d  = ~speaker_q;
            ack_d      = 1'b1;
            cur_note_d = note;
          end else begin
            state_d    = SILENT;
            req_d      = REST;
            speaker_d  = 1'b0;
            ack_d      = 1'b1;
            cur_note_d = 4'd0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SILENT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SILENT;
      cnt_q      <= '0;
      heff_q     <= '0;
      req_q      <= REST;
      speaker_q  <= 1'b0;
      ack_q      <= 1'b0;
      cur_note_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      heff_q     <= heff_d;
      req_q      <= req_d;
      speaker_q  <= speaker_d;
      ack_q      <= ack_d;
      cur_note_q <= cur_note_d;
    end
  end

  assign speaker  = speaker_q;
  assign active   = (state_q == PLAY);
  assign note_ack = ack_q;
  assign cur_note = cur_note_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// tb/tb_buzzer_tone_gen.sv - self-checking bench for buzzer_tone_gen

module tb_buzzer_tone_gen;

  localparam int TB_CLK_HZ = 100_000;

  logic       clk = 1'b0;
  logic       reset;
  logic       tone_en;
  logic [3:0] note;
  logic [1:0] octave;
  logic       speaker;
  logic       active;
  logic       note_ack;
  logic [3:0] cur_note;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // Reference model state: time-based description of the tone.
  logic       m_spk  = 1'b0;
  logic       m_play = 1'b0;
  logic       m_ack  = 1'b0;
  logic [3:0] m_cur  = 4'd0;
  int         m_lat_note = 0;
  int         m_lat_oct  = 0;
  int         m_heff = 0;
  int         m_seg  = 0;

  buzzer_tone_gen #(.CLK_HZ(TB_CLK_HZ), .CNT_W(20)) dut (
    .clk(clk), .reset(reset), .tone_en(tone_en), .note(note), .octave(octave),
    .speaker(speaker), .active(active), .note_ack(note_ack), .cur_note(cur_note)
  );

  always #5 clk = ~clk;

  function automatic int model_heff(input int n, input int oct);
    int  f [1:7];
    longint h;
    int  div;
    f[1] = 13081; f[2] = 14683; f[3] = 16481; f[4] = 17461;
    f[5] = 19600; f[6] = 22000; f[7] = 24694;
    h   = (longint'(TB_CLK_HZ) * 50) / f[n];
    div = (oct >= 2) ? 4 : (oct == 1 ? 2 : 1);
    return int'(h / div);
  endfunction

  // Advance one clock: the model consumes the inputs present at the edge.
  task automatic cycle();
    int rn, ro;
    bit rv;
    rv = tone_en && (note >= 1) && (note <= 7);
    rn = rv ? int'(note) : 0;
    ro = rv ? int'(octave) : 0;
    if (reset) begin
      m_play = 0; m_spk = 0; m_ack = 0; m_cur = 0; m_lat_note = 0; m_lat_oct = 0;
    end else if (!m_play) begin
      m_ack = 0;
      if (rn != 0) begin
        m_play = 1; m_lat_note = rn; m_lat_oct = ro; m_heff = model_heff(rn, ro);
        m_seg = cyc + 1; m_spk = 1; m_ack = 1; m_cur = 4'(rn);
      end
    end else begin
      m_ack = 0;
      if ((cyc + 1 - m_seg) == m_heff) begin
        m_seg = cyc + 1;
        if (rn == m_lat_note && ro == m_lat_oct) begin
          m_spk = !m_spk;
        end else if (rn != 0) begin
          m_lat_note = rn; m_lat_oct = ro; m_heff = model_heff(rn, ro);
          m_spk = !m_spk; m_ack = 1; m_cur = 4'(rn);
        end else begin
          m_play = 0; m_spk = 0; m_cur = 0; m_ack = 1; m_lat_note = 0; m_lat_oct = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1; tone_en = 1; note = 4'd5; octave = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if ({speaker, active, note_ack, cur_note} !== 7'b0) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, {speaker, active, note_ack, cur_note}, 7'b0);
      end
    end
    note = 0; reset = 0;
    cycle();
    vectors++;
    if ({speaker, active, note_ack, cur_note} !== 7'b0) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=%b", {speaker, active, note_ack, cur_note}, 7'b0);
    end
  endtask

  task automatic test_single_tone();
    int hi, lo, acks;
    note = 4'd1; octave = 0; tone_en = 1;
    cycle();
    vectors++;
    if ({speaker, active, note_ack, cur_note} !== 7'b1110001) begin
      errors++;
      $display("FAIL first_edge got=%b exp=%b", {speaker, active, note_ack, cur_note}, 7'b1110001);
    end
    hi = 1; acks = 0;
    for (int i = 0; i < 2000; i++) begin
      cycle();
      vectors++;
      if ({speaker, active, note_ack, cur_note} !== {m_spk, m_play, m_ack, m_cur}) begin
        errors++;
        $display("FAIL tone_model cyc=%0d got=%b exp=%b", cyc, {speaker, active, note_ack, cur_note}, {m_spk, m_play, m_ack, m_cur});
      end
      if (note_ack === 1'b1) acks++;
      if (speaker !== 1'b1) break;
      hi++;
    end
    lo = 1;
    for (int i = 0; i < 2000; i++) begin
      cycle();
      if (note_ack === 1'b1) acks++;
      if (speaker === 1'b1) break;
      lo++;
    end
    vectors++;
    if (hi != 382) begin errors++; $display("FAIL tone_high got=%0d exp=%0d", hi, 382); end
    vectors++;
    if (lo != 382) begin errors++; $display("FAIL tone_low got=%0d exp=%0d", lo, 382); end
    vectors++;
    if (acks != 0) begin errors++; $display("FAIL tone_extra_ack got=%0d exp=%0d", acks, 0); end
  endtask

  task automatic test_octave_change();
    int n, len;
    note = 4'd6; octave = 0;
    n = 0;
    do begin cycle(); n++; end while (note_ack !== 1'b1 && n < 2000);
    vectors++;
    if (note_ack !== 1'b1 || cur_note !== 4'd6) begin
      errors++;
      $display("FAIL oct_adopt6 got=%b/%0d exp=1/6", note_ack, cur_note);
    end
    n = 0;
    for (int i = 0; i < 50; i++) begin cycle(); n++; end
    octave = 2'd1;
    do begin
      cycle(); n++;
      vectors++;
      if ({speaker, active, note_ack, cur_note} !== {m_spk, m_play, m_ack, m_cur}) begin
        errors++;
        $display("FAIL oct_model cyc=%0d got=%b exp=%b", cyc, {speaker, active, note_ack, cur_note}, {m_spk, m_play, m_ack, m_cur});
      end
    end while (note_ack !== 1'b1 && n < 2000);
    vectors++;
    if (n != 227) begin errors++; $display("FAIL oct_boundary got=%0d exp=%0d", n, 227); end
    len = 1;
    begin
      logic lvl;
      lvl = speaker;
      for (int i = 0; i < 2000; i++) begin
        cycle();
        if (speaker !== lvl) break;
        len++;
      end
    end
    vectors++;
    if (len != 113) begin errors++; $display("FAIL oct_level got=%0d exp=%0d", len, 113); end
  endtask

  task automatic test_mute();
    int n;
    note = 4'd3; octave = 0;
    n = 0;
    do begin cycle(); n++; end while (note_ack !== 1'b1 && n < 2000);
    vectors++;
    if (cur_note !== 4'd3) begin errors++; $display("FAIL mute_adopt3 got=%0d exp=%0d", cur_note, 3); end
    n = 0;
    for (int i = 0; i < 30; i++) begin cycle(); n++; end
    tone_en = 0;
    do begin cycle(); n++; end while (note_ack !== 1'b1 && n < 2000);
    vectors++;
    if (n != 303) begin errors++; $display("FAIL mute_boundary got=%0d exp=%0d", n, 303); end
    vectors++;
    if ({speaker, active, cur_note} !== 6'b0) begin
      errors++;
      $display("FAIL mute_outputs got=%b exp=%b", {speaker, active, cur_note}, 6'b0);
    end
    for (int i = 0; i < 400; i++) begin
      cycle();
      vectors++;
      if ({speaker, active, note_ack, cur_note} !== {m_spk, m_play, m_ack, m_cur}) begin
        errors++;
        $display("FAIL mute_model cyc=%0d got=%b exp=%b", cyc, {speaker, active, note_ack, cur_note}, {m_spk, m_play, m_ack, m_cur});
      end
    end
  endtask

  task automatic test_invalid_and_glitch();
    int len, acks;
    tone_en = 1; note = 4'd9; octave = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      vectors++;
      if ({speaker, active, note_ack} !== 3'b000) begin
        errors++;
        $display("FAIL invalid_note cyc=%0d got=%b exp=%b", cyc, {speaker, active, note_ack}, 3'b000);
      end
    end
    note = 4'd2;
    cycle();
    vectors++;
    if ({speaker, note_ack, cur_note} !== 6'b110010) begin
      errors++;
      $display("FAIL glitch_start got=%b exp=%b", {speaker, note_ack, cur_note}, 6'b110010);
    end
    len = 1; acks = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 100) note = 4'd4;
      if (i == 150) note = 4'd2;
      cycle();
      if (note_ack === 1'b1) acks++;
      if (speaker !== 1'b1) break;
      len++;
    end
    vectors++;
    if (len != 340) begin errors++; $display("FAIL glitch_level got=%0d exp=%0d", len, 340); end
    vectors++;
    if (acks != 0) begin errors++; $display("FAIL glitch_ack got=%0d exp=%0d", acks, 0); end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    do begin cycle(); n++; end while (speaker !== 1'b1 && n < 2000);
    for (int i = 0; i < 20; i++) cycle();
    reset = 1;
    cycle();
    vectors++;
    if ({speaker, active, note_ack, cur_note} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid got=%b exp=%b", {speaker, active, note_ack, cur_note}, 7'b0);
    end
    reset = 0;
    cycle();
    vectors++;
    if ({speaker, active, note_ack, cur_note} !== 7'b1110010) begin
      errors++;
      $display("FAIL reset_restart got=%b exp=%b", {speaker, active, note_ack, cur_note}, 7'b1110010);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int s = 0; s < 30; s++) begin
      tone_en = ($urandom_range(0, 3) != 0);
      note    = 4'($urandom_range(0, 15));
      octave  = 2'($urandom_range(0, 3));
      reset   = ($urandom_range(0, 19) == 0);
      hold    = $urandom_range(1, 600);
      for (int i = 0; i < hold; i++) begin
        cycle();
        reset = 0;
        vectors++;
        if ({speaker, active, note_ack, cur_note} !== {m_spk, m_play, m_ack, m_cur}) begin
          errors++;
          $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, {speaker, active, note_ack, cur_note}, {m_spk, m_play, m_ack, m_cur});
        end
      end
    end
  endtask

  initial begin
    reset = 1; tone_en = 0; note = 0; octave = 0;
    test_reset();
    test_single_tone();
    test_octave_change();
    test_mute();
    test_invalid_and_glitch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
